// File: rtl/param_icache_if.sv
// Fetch-side and memory-side signal bundle for param_icache.
// master: datapath/memory environment; slave: the cache itself.
`timescale 1ns/1ps
interface param_icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inval;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (
    output imemREN, imemaddr, inval,
    output iwait, iload,
    input  ihit, imemload,
    input  iREN, iaddr,
    input  hit_count, miss_count
  );

  modport slave (
    input  imemREN, imemaddr, inval,
    input  iwait, iload,
    output ihit, imemload,
    output iREN, iaddr,
    output hit_count, miss_count
  );
endinterface

// File: rtl/param_icache.sv
// Parametrised 1/2-way instruction cache with multi-word fills,
// LRU replacement, single-cycle invalidate and hit/miss counters.
// Ports: CLK, RST (sync, active-high), bus (param_icache_if.slave):
//   fetch side imemREN/imemaddr/ihit/imemload/inval,
//   memory side iREN/iaddr/iwait/iload, counters hit_count/miss_count.
`timescale 1ns/1ps
module param_icache #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input logic           CLK,
  input logic           RST,
  param_icache_if.slave bus
);
  localparam int WO = $clog2(BLOCK_WORDS);
  localparam int IX = $clog2(SETS);
  localparam int TW = 30 - WO - IX;
  localparam int OW = (WO > 0) ? WO : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          r_state;
  logic [SETS-1:0] r_valid [WAYS];
  logic [TW-1:0]   r_tag   [WAYS][SETS];
  logic [31:0]     r_data  [WAYS][SETS][BLOCK_WORDS];
  logic [SETS-1:0] r_lru;
  logic [IX-1:0]   r_fidx;
  logic [TW-1:0]   r_ftag;
  logic            r_vway;
  logic [OW-1:0]   r_cnt;
  logic            r_iren;
  logic [31:0]     r_iaddr;
  logic [31:0]     r_hits;
  logic [31:0]     r_misses;

  logic [OW-1:0]   w_off;
  logic [IX-1:0]   w_idx;
  logic [TW-1:0]   w_tag;
  logic [1:0]      w_way_hit;
  logic            w_hway;
  logic            w_hit;
  logic            w_miss;
  logic            w_vic;
  logic            w_acc;
  logic            w_last;

  always_comb begin
    w_off = OW'((bus.imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
    w_idx = IX'(bus.imemaddr >> (2 + WO));
    w_tag = TW'(bus.imemaddr >> (2 + WO + IX));
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_way_hit[g] = r_valid[g][w_idx] &&
                          (r_tag[g][w_idx] == w_tag);
  end
  if (WAYS == 1) begin : g_one_way
    assign w_way_hit[1] = 1'b0;
  end

  // Way 1 can only be selected when it exists.
  assign w_hway = (WAYS == 2) & ~w_way_hit[0];

  // inval masks the hit in the same cycle it clears the lines.
  assign w_hit  = bus.imemREN & (r_state == IDLE) &
                  ~bus.inval & (|w_way_hit);
  assign w_miss = bus.imemREN & (r_state == IDLE) &
                  ~bus.inval & ~(|w_way_hit);
  assign w_acc  = (r_state == FILL) & ~bus.iwait;
  assign w_last = (r_cnt == OW'(BLOCK_WORDS - 1));

  // First invalid way wins (way 0 first), else the LRU way.
  always_comb begin
    w_vic = 1'b0;
    if (WAYS == 2 && r_valid[0][w_idx])
      w_vic = ~r_valid[WAYS-1][w_idx] | r_lru[w_idx];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_lru    <= '0;
      r_fidx   <= '0;
      r_ftag   <= '0;
      r_vway   <= 1'b0;
      r_cnt    <= '0;
      r_iren   <= 1'b0;
      r_iaddr  <= '0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_hit && r_hits != '1)
        r_hits <= r_hits + 32'd1;
      if (w_hit && WAYS == 2)
        r_lru[w_idx] <= ~w_hway;
      unique case (r_state)
        IDLE: begin
          if (bus.inval) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
          end else if (w_miss) begin
            r_state <= FILL;
            r_fidx  <= w_idx;
            r_ftag  <= w_tag;
            r_vway  <= w_vic;
            r_cnt   <= '0;
            r_iren  <= 1'b1;
            r_iaddr <= bus.imemaddr &
                       ~32'(BLOCK_WORDS * 4 - 1);
            if (r_misses != '1)
              r_misses <= r_misses + 32'd1;
          end
        end
        FILL: begin
          if (bus.inval) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            r_state <= IDLE;
            r_iren  <= 1'b0;
            r_iaddr <= '0;
          end else if (w_acc) begin
            r_cnt   <= r_cnt + OW'(1);
            r_iaddr <= r_iaddr + 32'd4;
            if (w_last) begin
              r_valid[r_vway][r_fidx] <= 1'b1;
              if (WAYS == 2) r_lru[r_fidx] <= ~r_vway;
              r_state <= IDLE;
              r_iren  <= 1'b0;
              r_iaddr <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data/tag writes need no reset; an aborted fill is never validated.
  always_ff @(posedge CLK) begin
    if (w_acc)
      r_data[r_vway][r_fidx][r_cnt] <= bus.iload;
    if (w_acc && w_last)
      r_tag[r_vway][r_fidx] <= r_ftag;
  end

  assign bus.ihit       = w_hit;
  assign bus.imemload   = w_hit ? r_data[w_hway][w_idx][w_off] : 32'd0;
  assign bus.iREN       = r_iren;
  assign bus.iaddr      = r_iaddr;
  assign bus.hit_count  = r_hits;
  assign bus.miss_count = r_misses;
endmodule
